// File: rtl/bram_arb_pkg.sv
// Shared definitions for the dual-port BRAM arbiter: port count and the
// per-port response slot state encoding.
package bram_arb_pkg;

   localparam int NUM_PORTS = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      VALID = 2'd1,
      HELD  = 2'd2
   } rsp_state_t;

endpackage

// File: rtl/bram_arb_rsp.sv
// Per-port response slot for the BRAM arbiter. Tracks one outstanding
// response, forwards BRAM read data in the cycle after the grant and parks
// it in a hold register when the requester is not ready, so later BRAM
// traffic from the other port cannot disturb it.
module bram_arb_rsp
   import bram_arb_pkg::*;
#(
   parameter int IO_DAT_WIDTH = 64
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    gnt,
   input  logic                    is_read,
   input  logic                    rready,
   input  logic [IO_DAT_WIDTH-1:0] ram_rddata,
   output logic                    rvalid,
   output logic                    free,
   output logic [IO_DAT_WIDTH-1:0] rdata
);

   rsp_state_t              state;
   logic                    read_q;
   logic [IO_DAT_WIDTH-1:0] hold_q;
   logic [IO_DAT_WIDTH-1:0] live_data;

   // Write responses carry zero data; reads show the BRAM output directly
   assign live_data = read_q ? ram_rddata : '0;

   // The slot can take a new access if empty or if its response drains now
   assign free = (state == EMPTY) || (rvalid && rready);

   // Response data comes live from the BRAM in VALID and from the hold register in HELD
   always_comb begin
      rdata = '0;
      case (state)
         VALID:   rdata = live_data;
         HELD:    rdata = hold_q;
         default: rdata = '0;
      endcase
   end

   // Response FSM with registered rvalid; hold register loads on entry to HELD
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         rvalid <= 1'b0;
         read_q <= 1'b0;
         hold_q <= '0;
      end else begin
         if (gnt) begin
            read_q <= is_read;
         end
         case (state)
            EMPTY: begin
               if (gnt) begin
                  state  <= VALID;
                  rvalid <= 1'b1;
               end
            end
            VALID: begin
               if (!rready) begin
                  state  <= HELD;
                  rvalid <= 1'b1;
                  hold_q <= live_data;
               end else if (gnt) begin
                  state  <= VALID;
                  rvalid <= 1'b1;
               end else begin
                  state  <= EMPTY;
                  rvalid <= 1'b0;
               end
            end
            HELD: begin
               if (rready) begin
                  state  <= gnt ? VALID : EMPTY;
                  rvalid <= gnt;
               end
            end
            default: begin
               state  <= EMPTY;
               rvalid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with one-cycle read
// latency. At most one access is issued per cycle; each port owns a
// response slot so responses can be back-pressured independently.
// Optional macro BRAM_ARB_ROUND_ROBIN_EN: round-robin between the ports on
// conflict; when undefined port 0 has fixed priority.
// IO_DAT_WIDTH must be a power of two between 8 and 64.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter  int BRAM_SIZE    = 16,
   parameter  int IO_DAT_WIDTH = 64,
   localparam int BE_W         = IO_DAT_WIDTH / 8,
   localparam int ADDR_W       = BRAM_SIZE + $clog2(IO_DAT_WIDTH / 8)
)
(
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    p0_req,
   output logic                    p0_gnt,
   input  logic [BE_W-1:0]         p0_we,
   input  logic [ADDR_W-1:0]       p0_addr,
   input  logic [IO_DAT_WIDTH-1:0] p0_wdata,
   output logic                    p0_rvalid,
   input  logic                    p0_rready,
   output logic [IO_DAT_WIDTH-1:0] p0_rdata,

   input  logic                    p1_req,
   output logic                    p1_gnt,
   input  logic [BE_W-1:0]         p1_we,
   input  logic [ADDR_W-1:0]       p1_addr,
   input  logic [IO_DAT_WIDTH-1:0] p1_wdata,
   output logic                    p1_rvalid,
   input  logic                    p1_rready,
   output logic [IO_DAT_WIDTH-1:0] p1_rdata,

   output logic                    ram_en,
   output logic [BE_W:0]           ram_we,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [IO_DAT_WIDTH-1:0] ram_wrdata,
   input  logic [IO_DAT_WIDTH-1:0] ram_rddata
);

   logic free0;
   logic free1;
   logic elig0;
   logic elig1;

   // No grants are issued while reset is asserted
   assign elig0 = p0_req && free0 && !rst;
   assign elig1 = p1_req && free1 && !rst;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
   logic last_p1;

   // Remember which port won most recently; reset state lets port 0 win first
   always_ff @(posedge clk) begin
      if (rst) begin
         last_p1 <= 1'b1;
      end else if (p0_gnt || p1_gnt) begin
         last_p1 <= p1_gnt;
      end
   end

   // On conflict the port that did not win last time is granted
   always_comb begin
      p0_gnt = elig0 && (!elig1 || last_p1);
      p1_gnt = elig1 && (!elig0 || !last_p1);
   end
`else
   // Fixed priority: port 0 always wins a conflict
   always_comb begin
      p0_gnt = elig0;
      p1_gnt = elig1 && !elig0;
   end
`endif

   assign ram_en = p0_gnt || p1_gnt;

   // Steer the granted port onto the BRAM; idle bus is driven to zero
   always_comb begin
      ram_we     = '0;
      ram_addr   = '0;
      ram_wrdata = '0;
      if (p0_gnt) begin
         ram_we     = {1'b0, p0_we};
         ram_addr   = p0_addr;
         ram_wrdata = p0_wdata;
      end else if (p1_gnt) begin
         ram_we     = {1'b0, p1_we};
         ram_addr   = p1_addr;
         ram_wrdata = p1_wdata;
      end
   end

   bram_arb_rsp #(
      .IO_DAT_WIDTH (IO_DAT_WIDTH)
   ) u_rsp0 (
      .clk        (clk),
      .rst        (rst),
      .gnt        (p0_gnt),
      .is_read    (~|p0_we),
      .rready     (p0_rready),
      .ram_rddata (ram_rddata),
      .rvalid     (p0_rvalid),
      .free       (free0),
      .rdata      (p0_rdata)
   );

   bram_arb_rsp #(
      .IO_DAT_WIDTH (IO_DAT_WIDTH)
   ) u_rsp1 (
      .clk        (clk),
      .rst        (rst),
      .gnt        (p1_gnt),
      .is_read    (~|p1_we),
      .rready     (p1_rready),
      .ram_rddata (ram_rddata),
      .rvalid     (p1_rvalid),
      .free       (free1),
      .rdata      (p1_rdata)
   );

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level model of the
// arbiter (per-port pending response, byte-level shadow memory).
module tb_bram_arbiter;
   import bram_arb_pkg::*;

   localparam int BRAM_SIZE    = 16;
   localparam int IO_DAT_WIDTH = 64;
   localparam int BE_W         = IO_DAT_WIDTH / 8;
   localparam int ADDR_W       = BRAM_SIZE + $clog2(BE_W);

   logic clk = 1'b0;
   logic rst;

   logic                    s_req    [NUM_PORTS];
   logic [BE_W-1:0]         s_we     [NUM_PORTS];
   logic [ADDR_W-1:0]       s_addr   [NUM_PORTS];
   logic [IO_DAT_WIDTH-1:0] s_wdata  [NUM_PORTS];
   logic                    s_rready [NUM_PORTS];

   logic                    p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [IO_DAT_WIDTH-1:0] p0_rdata, p1_rdata;
   logic                    ram_en;
   logic [BE_W:0]           ram_we;
   logic [ADDR_W-1:0]       ram_addr;
   logic [IO_DAT_WIDTH-1:0] ram_wrdata;
   logic [IO_DAT_WIDTH-1:0] ram_rddata;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: one pending response per port plus byte-addressed memory
   bit                      m_has  [NUM_PORTS];
   logic [IO_DAT_WIDTH-1:0] m_data [NUM_PORTS];
   bit                      pend   [NUM_PORTS];
   int                      m_last = 1;
   logic [7:0]              shadow [0:2047];

   // BRAM behaviour: word storage, one-cycle read latency, byte enables
   logic [IO_DAT_WIDTH-1:0] bram [0:255];

   always #5 clk = ~clk;

   bram_arbiter #(
      .BRAM_SIZE    (BRAM_SIZE),
      .IO_DAT_WIDTH (IO_DAT_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p0_req     (s_req[0]),
      .p0_gnt     (p0_gnt),
      .p0_we      (s_we[0]),
      .p0_addr    (s_addr[0]),
      .p0_wdata   (s_wdata[0]),
      .p0_rvalid  (p0_rvalid),
      .p0_rready  (s_rready[0]),
      .p0_rdata   (p0_rdata),
      .p1_req     (s_req[1]),
      .p1_gnt     (p1_gnt),
      .p1_we      (s_we[1]),
      .p1_addr    (s_addr[1]),
      .p1_wdata   (s_wdata[1]),
      .p1_rvalid  (p1_rvalid),
      .p1_rready  (s_rready[1]),
      .p1_rdata   (p1_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wrdata (ram_wrdata),
      .ram_rddata (ram_rddata)
   );

   // External BRAM responding to the arbiter's single access per cycle
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rddata <= bram[ram_addr[10:3]];
         for (int b = 0; b < BE_W; b++) begin
            if (ram_we[b]) bram[ram_addr[10:3]][b*8 +: 8] <= ram_wrdata[b*8 +: 8];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [63:0] shadowRead(input logic [ADDR_W-1:0] a);
      logic [63:0] v;
      int base;
      base = (int'(a) / 8) * 8;
      for (int b = 0; b < 8; b++) v[b*8 +: 8] = shadow[base + b];
      return v;
   endfunction

   task automatic setPort(input int i, input logic rq, input logic [BE_W-1:0] w,
                          input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic rr);
      s_req[i]    = rq;
      s_we[i]     = w;
      s_addr[i]   = a;
      s_wdata[i]  = d;
      s_rready[i] = rr;
   endtask

   task automatic randomPort(input int i);
      if (!pend[i]) begin
         s_req[i]   = ($urandom_range(0, 9) < 7);
         s_we[i]    = ($urandom_range(0, 1) == 1) ? BE_W'($urandom) : '0;
         s_addr[i]  = ADDR_W'($urandom_range(0, 31) * 8);
         s_wdata[i] = {$urandom, $urandom};
      end
      s_rready[i] = ($urandom_range(0, 3) != 0);
   endtask

   // One clock cycle: predict grant and responses at the negedge, then advance the model
   task automatic applyStimulus();
      logic                    g_act [NUM_PORTS];
      logic                    v_act [NUM_PORTS];
      logic [IO_DAT_WIDTH-1:0] d_act [NUM_PORTS];
      bit                      elig  [NUM_PORTS];
      int                      win;
      int                      base;
      @(negedge clk);
      g_act = '{p0_gnt, p1_gnt};
      v_act = '{p0_rvalid, p1_rvalid};
      d_act = '{p0_rdata, p1_rdata};
      win = -1;
      if (!rst) begin
         for (int i = 0; i < NUM_PORTS; i++) elig[i] = s_req[i] && (!m_has[i] || s_rready[i]);
         if (elig[0] && elig[1]) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            win = (m_last == 0) ? 1 : 0;
`else
            win = 0;
`endif
         end else if (elig[0]) begin
            win = 0;
         end else if (elig[1]) begin
            win = 1;
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         checkOutput($sformatf("p%0d_gnt", i), 64'(g_act[i]), 64'(win == i));
         checkOutput($sformatf("p%0d_rvalid", i), 64'(v_act[i]), 64'(m_has[i]));
         if (m_has[i]) checkOutput($sformatf("p%0d_rdata", i), d_act[i], m_data[i]);
      end
      checkOutput("ram_en", 64'(ram_en), 64'(win >= 0));
      if (win >= 0) begin
         checkOutput("ram_we", 64'(ram_we), 64'({1'b0, s_we[win]}));
         checkOutput("ram_addr", 64'(ram_addr), 64'(s_addr[win]));
         checkOutput("ram_wrdata", ram_wrdata, s_wdata[win]);
      end else begin
         checkOutput("ram_we_idle", 64'(ram_we), 64'd0);
      end
      for (int i = 0; i < NUM_PORTS; i++) pend[i] = s_req[i] && (win != i);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NUM_PORTS; i++) m_has[i] = 1'b0;
         m_last = 1;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) if (m_has[i] && s_rready[i]) m_has[i] = 1'b0;
         if (win >= 0) begin
            if (s_we[win] == '0) begin
               m_data[win] = shadowRead(s_addr[win]);
            end else begin
               m_data[win] = '0;
               base = (int'(s_addr[win]) / 8) * 8;
               for (int b = 0; b < BE_W; b++)
                  if (s_we[win][b]) shadow[base + b] = s_wdata[win][b*8 +: 8];
            end
            m_has[win] = 1'b1;
            m_last = win;
         end
      end
      #1;
   endtask

   // Directed scenarios, random traffic, then reset-in-flight
   initial begin
      for (int w = 0; w < 256; w++) bram[w] = '0;
      for (int b = 0; b < 2048; b++) shadow[b] = 8'h00;
      bram[4] = 64'hA5A5_A5A5_A5A5_A5A5;
      for (int b = 0; b < 8; b++) shadow[32 + b] = 8'hA5;
      for (int i = 0; i < NUM_PORTS; i++) begin
         setPort(i, 1'b0, '0, '0, '0, 1'b1);
         m_has[i] = 1'b0;
         pend[i]  = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_p0_gnt", 64'(p0_gnt), 64'd0);
      checkOutput("reset_p1_gnt", 64'(p1_gnt), 64'd0);
      checkOutput("reset_ram_en", 64'(ram_en), 64'd0);
      checkOutput("reset_p0_rvalid", 64'(p0_rvalid), 64'd0);
      checkOutput("reset_p1_rvalid", 64'(p1_rvalid), 64'd0);
      checkOutput("reset_p0_rdata", p0_rdata, 64'd0);
      checkOutput("reset_p1_rdata", p1_rdata, 64'd0);
      rst = 1'b0;

      // Full-width write then read back on port 0
      setPort(0, 1'b1, 8'hFF, 19'h10, 64'h1122334455667788, 1'b1);
      applyStimulus();
      setPort(0, 1'b1, 8'h00, 19'h10, 64'd0, 1'b1);
      applyStimulus();
      checkOutput("rd_after_wr_rvalid", 64'(p0_rvalid), 64'd1);
      checkOutput("rd_after_wr_rdata", p0_rdata, 64'h1122334455667788);
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      applyStimulus();

      // Partial byte-enable write into zeroed memory
      setPort(0, 1'b1, 8'h0F, 19'h8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      applyStimulus();
      setPort(0, 1'b1, 8'h00, 19'h8, 64'd0, 1'b1);
      applyStimulus();
      checkOutput("partial_wr_rdata", p0_rdata, 64'h0000_0000_FFFF_FFFF);
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      applyStimulus();

      // Write by port 0 immediately followed by read of same word from port 1
      setPort(0, 1'b1, 8'hFF, 19'h18, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
      applyStimulus();
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      setPort(1, 1'b1, 8'h00, 19'h18, 64'd0, 1'b1);
      applyStimulus();
      checkOutput("cross_port_rdata", p1_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      setPort(1, 1'b0, '0, '0, '0, 1'b1);
      applyStimulus();

      // Port 1 response back-pressured while port 0 overwrites the same word
      setPort(1, 1'b1, 8'h00, 19'h20, 64'd0, 1'b0);
      applyStimulus();
      for (int k = 0; k < 3; k++) begin
         setPort(0, 1'b1, 8'hFF, 19'h20, 64'h0123_4567_89AB_CDE0 + 64'(k), 1'b1);
         applyStimulus();
         checkOutput("held_rdata_stable", p1_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
      end
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      s_rready[1] = 1'b1;
      applyStimulus();
      checkOutput("held_regrant_rvalid", 64'(p1_rvalid), 64'd1);
      setPort(1, 1'b0, '0, '0, '0, 1'b1);
      applyStimulus();

      // Both ports requesting every cycle with responses always accepted
      for (int k = 0; k < 6; k++) begin
         setPort(0, 1'b1, 8'h00, 19'h40, 64'd0, 1'b1);
         setPort(1, 1'b1, 8'h00, 19'h48, 64'd0, 1'b1);
         applyStimulus();
      end
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      repeat (2) applyStimulus();
      setPort(1, 1'b0, '0, '0, '0, 1'b1);
      applyStimulus();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         randomPort(0);
         randomPort(1);
         applyStimulus();
      end

      // Drain, then reset one cycle after a read grant
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      setPort(1, 1'b0, '0, '0, '0, 1'b1);
      repeat (2) applyStimulus();
      setPort(0, 1'b1, 8'h00, 19'h10, 64'd0, 1'b1);
      applyStimulus();
      setPort(0, 1'b0, '0, '0, '0, 1'b1);
      rst = 1'b1;
      applyStimulus();
      checkOutput("post_rst_p0_rvalid", 64'(p0_rvalid), 64'd0);
      rst = 1'b0;
      applyStimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter BRAM_SIZE, default 16, meaning log2 of BRAM byte capacity, passed unchanged to the BRAM.
REQ-002 Parameter IO_DAT_WIDTH, default 64, meaning access data width in bits; SHALL be 8..64 and a power of two.
REQ-003 Localparams: ADDR_W = BRAM_SIZE+$clog2(IO_DAT_WIDTH/8); BE_W = IO_DAT_WIDTH/8.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 pN_req  in  1  port N (N=0,1) access request; held stable until granted.
REQ-007 pN_gnt  out  1  access accepted this cycle.
REQ-008 pN_we  in  BE_W  byte write enables; all-zero means read.
REQ-009 pN_addr  in  ADDR_W  byte address.
REQ-010 pN_wdata  in  IO_DAT_WIDTH  write data.
REQ-011 pN_rvalid  out  1  response valid, for reads and writes.
REQ-012 pN_rready  in  1  response accepted.
REQ-013 pN_rdata  out  IO_DAT_WIDTH  read data; 0 for write responses.
REQ-014 ram_en  out  1; ram_we  out  BE_W+1 (MSB tied 0); ram_addr  out  ADDR_W; ram_wrdata  out  IO_DAT_WIDTH; ram_rddata  in  IO_DAT_WIDTH, valid one cycle after ram_en.

Function
REQ-015 At most one BRAM access per cycle; ram_en SHALL equal p0_gnt|p1_gnt; gnts are one-hot or zero.
REQ-016 Port N is eligible when pN_req=1 and its response slot is EMPTY, or is VALID/HELD and drained this cycle (pN_rvalid&pN_rready).
REQ-017 ram_we/ram_addr/ram_wrdata SHALL be a combinational mux of the granted port's inputs; 0 when no grant.
REQ-018 Per-port response FSM: EMPTY -> VALID on grant; VALID -> EMPTY on rready with no new grant; VALID -> HELD on !rready; HELD -> EMPTY on rready; VALID/HELD -> VALID on rready with simultaneous grant.
REQ-019 VALID: pN_rvalid=1, pN_rdata=ram_rddata (read) or 0 (write); entry into HELD captures pN_rdata into a per-port hold register.
REQ-020 Latency: grant in cycle T gives rvalid in T+1; sustained throughput 1 access/cycle per port with rready=1.
REQ-021 Write in T from one port, read of same address from other port in T+1: read returns the new data.
REQ-022 HELD data SHALL remain stable despite later BRAM accesses by the other port.

Reset
REQ-023 On rst: pN_gnt=0, ram_en=0, both FSMs EMPTY, pN_rvalid=0, pN_rdata=0, hold registers 0, round-robin pointer favours port 0.
REQ-024 rst mid-operation discards in-flight/held responses; no response is emitted for them.

Configuration
REQ-025 Macro BRAM_ARB_ROUND_ROBIN_EN defined: on conflict, grant the port not granted most recently; pointer updates only on a grant.
REQ-026 Macro undefined: fixed priority, port 0 always wins conflicts; pointer logic absent.

Structure
REQ-027 Shared package bram_arb_pkg holds the response FSM state enum (EMPTY, VALID, HELD) and the port count constant (2).
REQ-028 One sub-module, bram_arb_rsp, implements the per-port response FSM and hold register, instantiated twice.

Verification
REQ-029 p0 writes 0x1122334455667788 @0x10, we=0xFF; p0 reads 0x10 -> p0_rvalid one cycle after gnt, rdata=0x1122334455667788.
REQ-030 Both req every cycle, rready=1, with _EN -> gnts alternate p0,p1,p0...; without _EN -> p0 granted every cycle, p1 never.
REQ-031 p1 read of 0x20 (holds 0xA5A5...), p1_rready=0 for 3 cycles while p0 writes 0x20 -> p1_rdata stays 0xA5A5... until accepted.
REQ-032 p1 has HELD response, p1_req=1, rready=0 -> p1_gnt=0; rready=1 -> p1_gnt=1 same cycle, new rvalid next cycle.
REQ-033 p0 write 0xFF..FF @0x8, we=0x0F, then read -> rdata=0x00000000FFFFFFFF from zeroed memory.
REQ-034 rst asserted one cycle after p0 read grant -> p0_rvalid=0 and ram_en=0 the cycle after rst.
